axi4_duth_noc_ni_flitizer: RTL and testbench



---
 rtl/axi4_duth_noc_ni_flitizer.sv | 149 ++++++++++++++
 tb/tb_axi4_duth_noc_ni_flitizer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_duth_noc_ni_flitizer.sv
// Generic NI serializer: splits header-tagged AXI-side beats into LINK_W-bit NoC flits.
// The first flit of a packet carries the full header; every other flit carries the small header.
module axi4_duth_noc_ni_flitizer #(
    parameter int PAYLOAD_W   = 40,
    parameter int LINK_W      = 32,
    parameter int HDR_FULL_W  = 12,
    parameter int HDR_SMALL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic                   in_last,
    input  logic [HDR_FULL_W-1:0]  in_hdr_full,
    input  logic [HDR_SMALL_W-1:0] in_hdr_small,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    output logic [LINK_W-1:0]      flit_data,
    output logic                   flit_head,
    output logic                   flit_tail
);
    localparam int CF      = LINK_W - HDR_FULL_W;
    localparam int CS      = LINK_W - HDR_SMALL_W;
    localparam int F1      = (PAYLOAD_W <= CF) ? 1 : 1 + (PAYLOAD_W - CF + CS - 1) / CS;
    localparam int FN      = (PAYLOAD_W + CS - 1) / CS;
    localparam int CNT_MAX = (F1 > FN) ? F1 : FN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int OFF_W   = $clog2(PAYLOAD_W + 1);
    localparam int WIDE_W  = PAYLOAD_W + LINK_W;

    localparam logic [CNT_W-1:0] F1_LAST = CNT_W'(F1 - 1);
    localparam logic [CNT_W-1:0] FN_LAST = CNT_W'(FN - 1);
    localparam logic [OFF_W-1:0] CF_STEP = OFF_W'(CF);
    localparam logic [OFF_W-1:0] CS_STEP = OFF_W'(CS);

    if (!(LINK_W > HDR_FULL_W && LINK_W > HDR_SMALL_W && PAYLOAD_W >= 1)) begin : g_param_check
        $error("axi4_duth_noc_ni_flitizer: need LINK_W > header widths and PAYLOAD_W >= 1");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic [HDR_SMALL_W-1:0] hdr_small_q;
    logic                   last_q;
    logic                   first_beat;
    logic [CNT_W-1:0]       idx;
    logic [CNT_W-1:0]       idx_last;
    logic [OFF_W-1:0]       off;

    logic                   flit_fire;
    logic                   last_flit;
    logic                   load;
    logic                   first_beat_nxt;
    logic [OFF_W-1:0]       off_nxt;
    logic [CNT_W-1:0]       idx_nxt;
    logic [CNT_W-1:0]       ld_last;
    logic [LINK_W-1:0]      ld_data;
    logic [LINK_W-1:0]      adv_data;

    // Header in the LSBs, then the next payload chunk starting at 'offset'; bits past the payload end shift in as zero.
    function automatic logic [LINK_W-1:0] pack_flit(
        input logic [PAYLOAD_W-1:0]   payload,
        input logic [OFF_W-1:0]       offset,
        input logic [HDR_FULL_W-1:0]  hdr_full,
        input logic [HDR_SMALL_W-1:0] hdr_small,
        input logic                   use_full
    );
        logic [WIDE_W-1:0] wide;
        logic [LINK_W-1:0] hdr;
        wide = {{LINK_W{1'b0}}, payload} >> offset;
        hdr  = '0;
        if (use_full) begin
            wide                = wide << HDR_FULL_W;
            hdr[HDR_FULL_W-1:0] = hdr_full;
        end else begin
            wide                 = wide << HDR_SMALL_W;
            hdr[HDR_SMALL_W-1:0] = hdr_small;
        end
        return wide[LINK_W-1:0] | hdr;
    endfunction

    always_comb begin
        flit_fire = flit_valid & flit_ready;
        last_flit = (idx == idx_last);
        in_ready  = (state == IDLE) | (flit_fire & last_flit);
        load      = in_valid & in_ready;
        // A tail accepted this cycle re-arms the full header even if a new beat loads in the same cycle.
        if (flit_fire & flit_tail)
            first_beat_nxt = 1'b1;
        else if (flit_fire & flit_head)
            first_beat_nxt = 1'b0;
        else
            first_beat_nxt = first_beat;
        off_nxt  = off + (flit_head ? CF_STEP : CS_STEP);
        idx_nxt  = idx + CNT_W'(1);
        ld_last  = first_beat_nxt ? F1_LAST : FN_LAST;
        ld_data  = pack_flit(in_payload, '0, in_hdr_full, in_hdr_small, first_beat_nxt);
        adv_data = pack_flit(payload_q, off_nxt, '0, hdr_small_q, 1'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            payload_q   <= '0;
            hdr_small_q <= '0;
            last_q      <= 1'b0;
            first_beat  <= 1'b1;
            idx         <= '0;
            idx_last    <= '0;
            off         <= '0;
            flit_valid  <= 1'b0;
            flit_data   <= '0;
            flit_head   <= 1'b0;
            flit_tail   <= 1'b0;
        end else begin
            first_beat <= first_beat_nxt;
            if (load) begin
                state       <= SEND;
                payload_q   <= in_payload;
                hdr_small_q <= in_hdr_small;
                last_q      <= in_last;
                idx         <= '0;
                idx_last    <= ld_last;
                off         <= '0;
                flit_valid  <= 1'b1;
                flit_data   <= ld_data;
                flit_head   <= first_beat_nxt;
                flit_tail   <= in_last & (ld_last == '0);
            end else if (flit_fire) begin
                if (!last_flit) begin
                    idx       <= idx_nxt;
                    off       <= off_nxt;
                    flit_data <= adv_data;
                    flit_head <= 1'b0;
                    flit_tail <= last_q & (idx_nxt == idx_last);
                end else begin
                    state      <= IDLE;
                    flit_valid <= 1'b0;
                    flit_data  <= '0;
                    flit_head  <= 1'b0;
                    flit_tail  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_duth_noc_ni_flitizer.sv
// Bench for axi4_duth_noc_ni_flitizer: several width configurations checked against a bit-level
// packetisation model of the flit format.
module tb_axi4_duth_noc_ni_flitizer;
    localparam int NI = 5;
    localparam int C_PW[NI] = '{40, 16, 1, 256, 100};
    localparam int C_LW[NI] = '{32, 32, 16, 128, 24};
    localparam int C_HF[NI] = '{12, 12, 12, 2, 7};
    localparam int C_HS[NI] = '{4, 4, 2, 12, 5};

    logic clk = 1'b0;
    logic rst_n;
    logic iv[NI], ir[NI], il[NI], fv[NI], fr[NI], fh[NI], ft[NI];
    logic [255:0] pay[NI];
    logic [11:0]  hf[NI];
    logic [11:0]  hs[NI];
    logic [127:0] fd[NI];
    logic [31:0]  fd0, fd1;
    logic [15:0]  fd2;
    logic [127:0] fd3;
    logic [23:0]  fd4;

    assign fd[0] = 128'(fd0);
    assign fd[1] = 128'(fd1);
    assign fd[2] = 128'(fd2);
    assign fd[3] = fd3;
    assign fd[4] = 128'(fd4);

    always #5 clk = ~clk;

    axi4_duth_noc_ni_flitizer #(.PAYLOAD_W(40), .LINK_W(32), .HDR_FULL_W(12), .HDR_SMALL_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_payload(pay[0][39:0]),
        .in_last(il[0]), .in_hdr_full(hf[0][11:0]), .in_hdr_small(hs[0][3:0]), .flit_valid(fv[0]),
        .flit_ready(fr[0]), .flit_data(fd0), .flit_head(fh[0]), .flit_tail(ft[0]));
    axi4_duth_noc_ni_flitizer #(.PAYLOAD_W(16), .LINK_W(32), .HDR_FULL_W(12), .HDR_SMALL_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_payload(pay[1][15:0]),
        .in_last(il[1]), .in_hdr_full(hf[1][11:0]), .in_hdr_small(hs[1][3:0]), .flit_valid(fv[1]),
        .flit_ready(fr[1]), .flit_data(fd1), .flit_head(fh[1]), .flit_tail(ft[1]));
    axi4_duth_noc_ni_flitizer #(.PAYLOAD_W(1), .LINK_W(16), .HDR_FULL_W(12), .HDR_SMALL_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_payload(pay[2][0:0]),
        .in_last(il[2]), .in_hdr_full(hf[2][11:0]), .in_hdr_small(hs[2][1:0]), .flit_valid(fv[2]),
        .flit_ready(fr[2]), .flit_data(fd2), .flit_head(fh[2]), .flit_tail(ft[2]));
    axi4_duth_noc_ni_flitizer #(.PAYLOAD_W(256), .LINK_W(128), .HDR_FULL_W(2), .HDR_SMALL_W(12)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_payload(pay[3][255:0]),
        .in_last(il[3]), .in_hdr_full(hf[3][1:0]), .in_hdr_small(hs[3][11:0]), .flit_valid(fv[3]),
        .flit_ready(fr[3]), .flit_data(fd3), .flit_head(fh[3]), .flit_tail(ft[3]));
    axi4_duth_noc_ni_flitizer #(.PAYLOAD_W(100), .LINK_W(24), .HDR_FULL_W(7), .HDR_SMALL_W(5)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_payload(pay[4][99:0]),
        .in_last(il[4]), .in_hdr_full(hf[4][6:0]), .in_hdr_small(hs[4][4:0]), .flit_valid(fv[4]),
        .flit_ready(fr[4]), .flit_data(fd4), .flit_head(fh[4]), .flit_tail(ft[4]));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] data;
        bit           head;
        bit           tail;
        bit           lob;
    } flit_t;

    flit_t        exp_q[$];
    logic [127:0] obs_d[$];
    bit           obs_h[$];
    bit           obs_t[$];
    int           nbeats;
    logic [255:0] beat_pay[8];
    logic [11:0]  beat_hs[8];
    logic [11:0]  beat_hf;
    int           rp_span;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Packet -> flit list: walk each beat's payload bit by bit, header first, until the payload is used up.
    function automatic void build_expected(input int k);
        flit_t       fl;
        int          off, f, hw;
        bit          full;
        logic [11:0] h;
        exp_q.delete();
        for (int b = 0; b < nbeats; b++) begin
            off = 0;
            f   = 0;
            while (off < C_PW[k]) begin
                full    = (b == 0) && (f == 0);
                hw      = full ? C_HF[k] : C_HS[k];
                h       = full ? beat_hf : beat_hs[b];
                fl.data = '0;
                for (int i = 0; i < hw; i++) fl.data[i] = h[i];
                for (int i = 0; i < C_LW[k] - hw; i++)
                    if (off + i < C_PW[k]) fl.data[hw + i] = beat_pay[b][off + i];
                off     = off + C_LW[k] - hw;
                fl.head = full;
                fl.lob  = (off >= C_PW[k]);
                fl.tail = fl.lob && (b == nbeats - 1);
                exp_q.push_back(fl);
                f++;
            end
        end
    endfunction

    // mode 0: sink always ready; mode 1: random valid/ready gaps; mode 2: sink stalls 5 cycles on flit 1.
    task automatic run_packet(input int k, input int mode);
        int           bi, fi, cyc, stall_cnt, first_fv, last_fv;
        bit           held, lat_pending;
        logic [127:0] held_d;
        logic         held_h, held_t, exp_ir;
        build_expected(k);
        obs_d.delete(); obs_h.delete(); obs_t.delete();
        bi = 0; fi = 0; cyc = 0; stall_cnt = 0; first_fv = -1; last_fv = -1;
        held = 0; lat_pending = 0; held_d = '0; held_h = 0; held_t = 0;
        @(posedge clk); #1;
        while (fi < exp_q.size() && cyc < 1000) begin
            if (bi < nbeats && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                iv[k]  = 1'b1;
                pay[k] = beat_pay[bi];
                hs[k]  = beat_hs[bi];
                hf[k]  = (bi == 0) ? beat_hf : 12'($urandom);
                il[k]  = (bi == nbeats - 1);
            end else begin
                iv[k]  = 1'b0;
                pay[k] = rand256();
                il[k]  = 1'($urandom_range(0, 1));
            end
            case (mode)
                0:       fr[k] = 1'b1;
                1:       fr[k] = ($urandom_range(0, 3) != 0);
                default: fr[k] = !(fi == 1 && stall_cnt < 5);
            endcase
            @(negedge clk);
            if (lat_pending) begin
                checks++;
                if (fv[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL latency inst%0d cyc%0d: flit_valid=%b expected 1", k, cyc, fv[k]);
                end
            end
            lat_pending = 0;
            if (held) begin
                checks++;
                if (fv[k] !== 1'b1 || fd[k] !== held_d || fh[k] !== held_h || ft[k] !== held_t) begin
                    errors++;
                    $display("FAIL stall_hold inst%0d: got v=%b d=%h h=%b t=%b expected v=1 d=%h h=%b t=%b",
                             k, fv[k], fd[k], fh[k], ft[k], held_d, held_h, held_t);
                end
            end
            held = 0;
            if (fv[k] === 1'b1) begin
                if (first_fv < 0) first_fv = cyc;
                last_fv = cyc;
                checks++;
                if (fd[k] !== exp_q[fi].data) begin
                    errors++;
                    $display("FAIL data inst%0d flit%0d: got %h expected %h", k, fi, fd[k], exp_q[fi].data);
                end
                checks++;
                if (fh[k] !== exp_q[fi].head || ft[k] !== exp_q[fi].tail) begin
                    errors++;
                    $display("FAIL flags inst%0d flit%0d: got head=%b tail=%b expected head=%b tail=%b",
                             k, fi, fh[k], ft[k], exp_q[fi].head, exp_q[fi].tail);
                end
                exp_ir = fr[k] & exp_q[fi].lob;
                checks++;
                if (ir[k] !== exp_ir) begin
                    errors++;
                    $display("FAIL in_ready inst%0d flit%0d: got %b expected %b", k, fi, ir[k], exp_ir);
                end
                if (fr[k]) begin
                    obs_d.push_back(fd[k]);
                    obs_h.push_back(fh[k]);
                    obs_t.push_back(ft[k]);
                    fi++;
                end else begin
                    held   = 1;
                    held_d = fd[k];
                    held_h = fh[k];
                    held_t = ft[k];
                    if (fi == 1) stall_cnt++;
                end
            end else begin
                checks++;
                if (ir[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_idle inst%0d cyc%0d: in_ready=%b expected 1", k, cyc, ir[k]);
                end
            end
            if (iv[k] === 1'b1 && ir[k] === 1'b1) begin
                bi++;
                lat_pending = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv[k]   = 1'b0;
        fr[k]   = 1'b1;
        rp_span = last_fv - first_fv + 1;
        checks++;
        if (fi < exp_q.size()) begin
            errors++;
            $display("FAIL timeout inst%0d: got %0d flits expected %0d", k, fi, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (fv[k] !== 1'b0 || fd[k] !== '0 || fh[k] !== 1'b0 || ft[k] !== 1'b0 || ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset inst%0d: got v=%b d=%h h=%b t=%b rdy=%b expected v=0 d=0 h=0 t=0 rdy=1",
                         k, fv[k], fd[k], fh[k], ft[k], ir[k]);
            end
        end
        @(posedge clk); #3; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (fv[k] !== 1'b0 || ir[k] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset inst%0d: got v=%b rdy=%b expected v=0 rdy=1", k, fv[k], ir[k]);
            end
        end
    endtask

    task automatic test_spec_vector();
        nbeats      = 1;
        beat_pay[0] = 256'h00AB_CDEF_0123;
        beat_hf     = 12'h5A5;
        beat_hs[0]  = 12'h003;
        run_packet(0, 0);
        checks++;
        if (obs_d.size() != 2) begin
            errors++;
            $display("FAIL vector_count: got %0d flits expected 2", obs_d.size());
        end else begin
            checks++;
            if (obs_d[0] !== 128'hF012_35A5 || obs_h[0] !== 1'b1 || obs_t[0] !== 1'b0) begin
                errors++;
                $display("FAIL vector_flit0: got %h h=%b t=%b expected f01235a5 h=1 t=0", obs_d[0], obs_h[0], obs_t[0]);
            end
            checks++;
            if (obs_d[1] !== 128'h00AB_CDE3 || obs_h[1] !== 1'b0 || obs_t[1] !== 1'b1) begin
                errors++;
                $display("FAIL vector_flit1: got %h h=%b t=%b expected 00abcde3 h=0 t=1", obs_d[1], obs_h[1], obs_t[1]);
            end
        end
    endtask

    task automatic test_single_flit();
        nbeats      = 1;
        beat_pay[0] = 256'hBEEF;
        beat_hf     = 12'h123;
        beat_hs[0]  = 12'h00A;
        run_packet(1, 0);
        checks++;
        if (obs_d.size() != 1 || obs_d[0] !== 128'h0BEE_F123 || obs_h[0] !== 1'b1 || obs_t[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_flit: got n=%0d d=%h expected n=1 d=0beef123 head=tail=1",
                     obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : '0);
        end
    endtask

    task automatic test_back_to_back();
        nbeats      = 3;
        beat_pay[0] = 256'(40'h0101010101);
        beat_pay[1] = 256'(40'h0202020202);
        beat_pay[2] = 256'(40'h0303030303);
        beat_hf     = 12'h7C1;
        beat_hs[0]  = 12'h005;
        beat_hs[1]  = 12'h009;
        beat_hs[2]  = 12'h00E;
        run_packet(0, 0);
        checks++;
        if (obs_d.size() != 6 || rp_span != 6) begin
            errors++;
            $display("FAIL back_to_back: got %0d flits over %0d cycles expected 6 over 6", obs_d.size(), rp_span);
        end
    endtask

    task automatic test_stall();
        nbeats      = 2;
        beat_pay[0] = rand256();
        beat_pay[1] = rand256();
        beat_hf     = 12'($urandom);
        beat_hs[0]  = 12'($urandom);
        beat_hs[1]  = 12'($urandom);
        run_packet(0, 2);
        checks++;
        if (rp_span != 4 + 5) begin
            errors++;
            $display("FAIL stall_span: got %0d valid cycles expected 9", rp_span);
        end
    endtask

    task automatic test_async_reset();
        iv[0]  = 1'b1;
        pay[0] = rand256();
        hf[0]  = 12'h111;
        hs[0]  = 12'h002;
        il[0]  = 1'b0;
        fr[0]  = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (fv[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: flit_valid=%b expected 1", fv[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fv[0] !== 1'b0 || fd[0] !== '0 || fh[0] !== 1'b0 || ft[0] !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: got v=%b d=%h h=%b t=%b expected all 0", fv[0], fd[0], fh[0], ft[0]);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        fr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fv[0] !== 1'b0) begin
                errors++;
                $display("FAIL areset_quiet cycle%0d: flit_valid=%b expected 0", i, fv[0]);
            end
        end
        nbeats      = 1;
        beat_pay[0] = rand256();
        beat_hf     = 12'h3C3;
        beat_hs[0]  = 12'h00F;
        run_packet(0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 6; p++) begin
                nbeats  = $urandom_range(1, 4);
                beat_hf = 12'($urandom);
                for (int b = 0; b < nbeats; b++) begin
                    beat_pay[b] = rand256();
                    beat_hs[b]  = 12'($urandom);
                end
                run_packet(k, (p == 0) ? 0 : 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; fr[k] = 1'b1;
            pay[k] = '0; hf[k] = '0; hs[k] = '0;
        end
        test_reset();
        test_spec_vector();
        test_single_flit();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
